// File: rtl/shift_logic_pkg.sv
// Shared encodings for the iterative shift/logic unit: operation codes and FSM states.
package shift_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_SLL = 3'd3,
        OP_SRL = 3'd4,
        OP_SRA = 3'd5,
        OP_ROL = 3'd6,
        OP_ROR = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic is_shift(input op_e op);
        return (op >= OP_SLL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate by 0..STEP bit positions; the top iterates it to reach the full amount.
module shift_step
    import shift_logic_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(STEP + 1)
) (
    input  op_e              op,
    input  logic [XLEN-1:0]  data_in,
    input  logic [AMT_W-1:0] amt,
    output logic [XLEN-1:0]  data_out
);

    localparam int RW = $clog2(XLEN) + 1;

    logic [RW-1:0] amt_w;
    logic [RW-1:0] inv_amt;

    // A zero amount gives inv_amt == XLEN, whose shift yields zero, so rotates stay correct.
    always_comb begin
        amt_w    = RW'(amt);
        inv_amt  = RW'(XLEN) - amt_w;
        data_out = data_in;
        case (op)
            OP_SLL:  data_out = data_in << amt_w;
            OP_SRL:  data_out = data_in >> amt_w;
            OP_SRA:  data_out = $signed(data_in) >>> amt_w;
            OP_ROL:  data_out = (data_in << amt_w) | (data_in >> inv_amt);
            OP_ROR:  data_out = (data_in >> amt_w) | (data_in << inv_amt);
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_logic_unit.sv
// Iterative shift/rotate/logic unit: logic ops finish on accept, shifts walk STEP bits per cycle.
module shift_logic_unit
    import shift_logic_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int TAGW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      op_sel,
    input  logic [TAGW-1:0] tag_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res,
    output logic [TAGW-1:0] tag_out
);

    localparam int SHW   = $clog2(XLEN);
    localparam int CW    = SHW + 1;
    localparam int AMT_W = $clog2(STEP + 1);

    state_e          state;
    op_e             op_in;
    op_e             op_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] step_out;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   step_cnt;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   shamt_in;
    logic [AMT_W-1:0] step_amt;
    logic [TAGW-1:0] tag_q;

    function automatic logic [XLEN-1:0] quick_result(
        input op_e             op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a;
        endcase
    endfunction

    assign op_in    = op_e'(op_sel);
    assign shamt_in = CW'(op2[SHW-1:0]);
    assign busy     = (state == S_RUN);

    // Counter is one bit wider than the shift amount so STEP == XLEN still fits.
    assign step_cnt = (cnt_q > CW'(STEP)) ? CW'(STEP) : cnt_q;
    assign step_amt = AMT_W'(step_cnt);
    assign cnt_next = cnt_q - step_cnt;

    shift_step #(
        .XLEN  (XLEN),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .op       (op_q),
        .data_in  (data_q),
        .amt      (step_amt),
        .data_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= OP_AND;
            data_q  <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            done    <= 1'b0;
            res     <= '0;
            tag_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q   <= op_in;
                        data_q <= op1;
                        tag_q  <= tag_in;
                        if (is_shift(op_in) && (shamt_in != '0)) begin
                            cnt_q <= shamt_in;
                            state <= S_RUN;
                        end else begin
                            cnt_q   <= '0;
                            done    <= 1'b1;
                            res     <= quick_result(op_in, op1, op2);
                            tag_out <= tag_in;
                        end
                    end
                end
                S_RUN: begin
                    // Flush drops the operation silently; res/tag_out keep the last completed result.
                    if (flush) begin
                        cnt_q <= '0;
                        state <= S_IDLE;
                    end else begin
                        data_q <= step_out;
                        cnt_q  <= cnt_next;
                        if (cnt_next == '0) begin
                            state   <= S_IDLE;
                            done    <= 1'b1;
                            res     <= step_out;
                            tag_out <= tag_q;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
